// File: rtl/cfu_output_packer.sv
// Packs four int8 quantizer results into little-endian 32-bit words behind a 2-entry output FIFO.
// Optional flush of partial words is enabled by defining CFU_PACKER_FLUSH_EN.
module cfu_output_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  lane
);

  logic [1:0]  r_lane;
  logic [23:0] r_asm;
  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;

  logic        w_acc;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_byte;
  logic [23:0] w_asm;
  logic [23:0] w_asm_nxt;
  logic [31:0] w_push_data;
  logic [1:0]  w_lane_nxt;
  logic [1:0]  w_count_nxt;
  logic        w_unused;

  assign w_byte = in_data[7:0];

`ifdef CFU_PACKER_FLUSH_EN
  assign w_unused = &{1'b0, in_data[31:8]};
`else
  assign w_unused = &{1'b0, in_data[31:8], flush};
`endif

  always_comb begin
    w_acc       = in_valid & r_in_ready;
    w_pop       = (r_count != 2'd0) & out_ready;
    w_asm       = r_asm;
    w_lane_nxt  = r_lane;
    w_push      = 1'b0;
    w_push_data = {w_byte, r_asm};
    if (w_acc) begin
      case (r_lane)
        2'd0:    w_asm[7:0]   = w_byte;
        2'd1:    w_asm[15:8]  = w_byte;
        2'd2:    w_asm[23:16] = w_byte;
        default: w_asm        = r_asm;
      endcase
      w_lane_nxt = r_lane + 2'd1;
      w_push     = (r_lane == 2'd3);
    end
`ifdef CFU_PACKER_FLUSH_EN
    // Flush sees the assembly after any same-cycle byte; a completed word already left lane 0.
    if (flush && (w_lane_nxt != 2'd0) && (r_count != 2'd2)) begin
      w_push      = 1'b1;
      w_push_data = {8'h00, w_asm};
      w_lane_nxt  = 2'd0;
    end
`endif
    w_asm_nxt   = (w_lane_nxt == 2'd0) ? '0 : w_asm;
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane     <= '0;
      r_asm      <= '0;
      r_mem      <= '{default: '0};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_lane  <= w_lane_nxt;
      r_asm   <= w_asm_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Stall only when the next byte would complete a word with nowhere to go.
      r_in_ready <= !((w_lane_nxt == 2'd3) && (w_count_nxt == 2'd2));
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign lane      = r_lane;

endmodule

// File: doc/cfu_output_packer.md
CFU_OUTPUT_PACKER -- requirements
Module: cfu_output_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  quantizer result on in_data is valid.
REQ-005 in_ready  output  1  packer accepts in_data this cycle.
REQ-006 in_data  input  32  signed quantizer data_out, already clamped to int8 range.
REQ-007 flush  input  1  single-cycle request to emit a partially filled word.
REQ-008 out_valid  output  1  packed word on out_data is valid.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  32  four packed int8 results.
REQ-011 lane  output  2  number of bytes held in the assembly register (0..3).

Function
REQ-012 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer on out_valid=1 and out_ready=1.
REQ-013 An accepted byte SHALL be in_data[7:0], with bits [31:8] ignored and no saturation applied.
REQ-014 Byte k of a word (k = lane at acceptance) SHALL occupy out_data[8k+7:8k], little-endian.
REQ-015 Each accepted byte SHALL increment lane; acceptance at lane=3 SHALL push the completed word into a 2-entry FIFO and wrap lane to 0.
REQ-016 A pushed word SHALL appear on out_valid/out_data in the cycle after the 4th byte is accepted (latency 1).
REQ-017 out_data SHALL present the FIFO head and remain stable while out_valid=1 and out_ready=0.
REQ-018 in_ready SHALL be registered: in_ready=0 exactly when lane=3 and the FIFO holds 2 words; otherwise 1.
REQ-019 in_ready SHALL NOT depend combinationally on out_ready; a pop from a full FIFO SHALL raise in_ready on the following cycle.
REQ-020 A simultaneous push and pop SHALL leave FIFO occupancy unchanged and preserve word order.
REQ-021 Unfilled byte lanes of the assembly register SHALL be zero.
REQ-022 Bytes SHALL never be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-023 While rst=1, lane=0, the FIFO SHALL be empty, out_valid=0, out_data=0, and in_ready=1 on the following edge.
REQ-024 Reset mid-word SHALL discard partial bytes and buffered words, with no output transfer in the reset cycle.

Configuration
REQ-025 Macro CFU_PACKER_FLUSH_EN SHALL control flush support.
REQ-026 With CFU_PACKER_FLUSH_EN defined, flush=1 with lane>0 and FIFO not full SHALL push the zero-padded partial word and set lane=0.
REQ-027 With CFU_PACKER_FLUSH_EN defined, flush with a same-cycle accepted byte SHALL include that byte in the flushed word.
REQ-028 With CFU_PACKER_FLUSH_EN defined, flush with lane=0 (after any same-cycle byte) SHALL have no effect.
REQ-029 With CFU_PACKER_FLUSH_EN defined, flush with a full FIFO SHALL be ignored and lane SHALL be unchanged.
REQ-030 Without CFU_PACKER_FLUSH_EN, the flush port SHALL remain present and SHALL be ignored.

Verification
REQ-031 Bytes -122, -128, -76, 5 with out_ready=1 -> one cycle later out_valid=1, out_data=0x05B48086, lane=0.
REQ-032 in_data=0xFFFFFF86 and 0x00000086 each as byte 0 of a word -> byte 0 = 0x86 in both words.
REQ-033 out_ready=0 and 12 bytes offered -> two words buffered, 11 bytes accepted, in_ready=0 at lane=3; one pop raises in_ready next cycle, 12th byte accepted, and 3 words emerge in order.
REQ-034 CFU_PACKER_FLUSH_EN defined, bytes 127 and -1, then flush -> out_data=0x0000FF7F; without the macro the same stimulus leaves lane=2 and out_valid=0.
REQ-035 Two bytes accepted, then rst high for 1 cycle, then bytes 1, 2, 3, 4 -> out_data=0x04030201 and no stale word.
REQ-036 FIFO holding 1 word with out_ready=1 continuously and 4th byte accepted in the same cycle as the pop -> occupancy stays 1 and the next word follows in order.
